// File: rtl/vec_ctrl_pkg.sv
// Shared types and encodings for the vector sequencing controller.
// Used by vec_ctrl_decoder and vector_processor_controller.
package vec_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StCsr,
      StLoad,
      StStore,
      StWrite
   } state_e;

   typedef enum logic [2:0] {
      ClsIllegal,
      ClsCsr,
      ClsArith,
      ClsLoad,
      ClsStore
   } inst_class_e;

   localparam logic [6:0] OpcodeV     = 7'h57;
   localparam logic [6:0] OpcodeLoad  = 7'h07;
   localparam logic [6:0] OpcodeStore = 7'h27;

   localparam logic [2:0] F3Opivv = 3'b000;
   localparam logic [2:0] F3Opivi = 3'b011;
   localparam logic [2:0] F3Opivx = 3'b100;
   localparam logic [2:0] F3Opcfg = 3'b111;

   localparam logic [1:0] MopUnit    = 2'b00;
   localparam logic [1:0] MopStrided = 2'b10;

   localparam logic [1:0] Mux1Vs1    = 2'b00;
   localparam logic [1:0] Mux1Scalar = 2'b01;
   localparam logic [1:0] Mux1Imm    = 2'b10;

   typedef struct packed {
      logic       vl_sel;
      logic       vtype_sel;
      logic       rs1rd_de;
      logic       rs1_sel;
      logic       stride_sel;
      logic       lumop_sel;
      logic       addr_mux2_sel;
      logic [1:0] arith_mux1_sel;
      logic       mask_op;
   } dec_sel_t;

   // Operand-1 source for OPIVV / OPIVX / OPIVI.
   function automatic logic [1:0] f3_to_mux1(input logic [2:0] f3);
      logic [1:0] sel;
      sel = Mux1Vs1;
      if (f3 == F3Opivx) sel = Mux1Scalar;
      if (f3 == F3Opivi) sel = Mux1Imm;
      return sel;
   endfunction

endpackage

// File: rtl/vec_ctrl_decoder.sv
// Combinational RVV instruction classifier: latched instruction word in,
// instruction class and datapath select bundle out.
module vec_ctrl_decoder
   import vec_ctrl_pkg::*;
#(
   parameter int unsigned XLEN_P = 32
) (
   input  logic [XLEN_P-1:0] inst_i,
   output inst_class_e       cls_o,
   output dec_sel_t          sel_o
);

   logic [6:0] opcode;
   logic [4:0] rd;
   logic [2:0] funct3;
   logic [4:0] rs1;
   logic [1:0] mop;
   logic       unused_bits;

   assign opcode      = inst_i[6:0];
   assign rd          = inst_i[11:7];
   assign funct3      = inst_i[14:12];
   assign rs1         = inst_i[19:15];
   assign mop         = inst_i[27:26];
   assign unused_bits = ^{inst_i[28], inst_i[25:20]};

   always_comb begin
      cls_o = ClsIllegal;
      unique case (opcode)
         OpcodeV: begin
            unique case (funct3)
               F3Opcfg:                   cls_o = ClsCsr;
               F3Opivv, F3Opivx, F3Opivi: cls_o = ClsArith;
               default:                   cls_o = ClsIllegal;
            endcase
         end
         OpcodeLoad:  cls_o = ClsLoad;
         OpcodeStore: cls_o = ClsStore;
         default:     cls_o = ClsIllegal;
      endcase
   end

   always_comb begin
      sel_o               = '0;
      sel_o.vl_sel        = (inst_i[31:30] == 2'b11);
      sel_o.vtype_sel     = !inst_i[31] || (inst_i[31:30] == 2'b11);
      sel_o.rs1rd_de      = (rs1 != 5'd0);
      sel_o.rs1_sel       = (rs1 == 5'd0) && (rd != 5'd0);
      sel_o.stride_sel    = (mop == MopUnit);
      sel_o.lumop_sel     = (mop == MopUnit);
      sel_o.addr_mux2_sel = (mop == MopStrided);
      // The WRITE that follows a load takes vs1 path; funct3 there is a width.
      if (opcode == OpcodeV) begin
         sel_o.arith_mux1_sel = f3_to_mux1(funct3);
         sel_o.mask_op        = (inst_i[31:29] == 3'b011);
      end
   end

endmodule

// File: rtl/vector_processor_controller.sv
// Sequencing FSM for the vector datapath: accept, decode, drive selects, wait for completion.
// Optional per-wait-state watchdog enabled by defining VEC_CTRL_TIMEOUT_EN.
module vector_processor_controller
   import vec_ctrl_pkg::*;
#(
   parameter int unsigned XLEN_P         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_valid,
   input  logic [XLEN_P-1:0] instruction,
   output logic              inst_ready,
   output logic              busy,
   input  logic              csr_done,
   input  logic              is_loaded,
   input  logic              store_done,
   input  logic              data_written,
   output logic              vl_sel,
   output logic              vtype_sel,
   output logic              lumop_sel,
   output logic              rs1rd_de,
   output logic              rs1_sel,
   output logic              csrwr_en,
   output logic              vec_reg_wr_en,
   output logic              mask_operation,
   output logic              mask_wr_en,
   output logic [1:0]        data_mux1_sel,
   output logic              data_mux2_sel,
   output logic              stride_sel,
   output logic              ld_inst,
`ifdef VEC_CTRL_TIMEOUT_EN
   output logic              timeout_err,
`endif
   output logic              illegal_inst
);

   state_e            state_q, state_d;
   logic [XLEN_P-1:0] inst_q;
   logic              entry_q;
   inst_class_e       cls;
   dec_sel_t          sel;

   vec_ctrl_decoder #(
      .XLEN_P (XLEN_P)
   ) u_decoder (
      .inst_i (inst_q),
      .cls_o  (cls),
      .sel_o  (sel)
   );

`ifdef VEC_CTRL_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q;
   logic            wait_state;
   logic            timeout_hit;

   assign wait_state  = (state_q == StCsr) || (state_q == StLoad) ||
                        (state_q == StStore) || (state_q == StWrite);
   assign timeout_hit = wait_state && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset || (state_d != state_q)) begin
         cnt_q <= '0;
      end else if (wait_state) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   localparam int unsigned UnusedTimeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         inst_q  <= '0;
         entry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         entry_q <= (state_d != state_q);
         if ((state_q == StIdle) && inst_valid) begin
            inst_q <= instruction;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      inst_ready     = 1'b0;
      busy           = (state_q != StIdle);
      vl_sel         = 1'b0;
      vtype_sel      = 1'b0;
      lumop_sel      = 1'b0;
      rs1rd_de       = 1'b0;
      rs1_sel        = 1'b0;
      csrwr_en       = 1'b0;
      vec_reg_wr_en  = 1'b0;
      mask_operation = 1'b0;
      mask_wr_en     = 1'b0;
      data_mux1_sel  = Mux1Vs1;
      data_mux2_sel  = 1'b0;
      stride_sel     = 1'b0;
      ld_inst        = 1'b0;
      illegal_inst   = 1'b0;
`ifdef VEC_CTRL_TIMEOUT_EN
      timeout_err    = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            inst_ready = 1'b1;
            if (inst_valid) state_d = StDecode;
         end
         StDecode: begin
            unique case (cls)
               ClsCsr:   state_d = StCsr;
               ClsArith: state_d = StWrite;
               ClsLoad:  state_d = StLoad;
               ClsStore: state_d = StStore;
               default: begin
                  illegal_inst = 1'b1;
                  state_d      = StIdle;
               end
            endcase
         end
         StCsr: begin
            // The CSR write is a single strobe on the entry cycle only.
            csrwr_en  = entry_q;
            vl_sel    = sel.vl_sel;
            vtype_sel = sel.vtype_sel;
            rs1rd_de  = sel.rs1rd_de;
            rs1_sel   = sel.rs1_sel;
            if (csr_done) state_d = StIdle;
         end
         StLoad: begin
            ld_inst       = 1'b1;
            vec_reg_wr_en = 1'b1;
            data_mux1_sel = Mux1Scalar;
            stride_sel    = sel.stride_sel;
            lumop_sel     = sel.lumop_sel;
            data_mux2_sel = sel.addr_mux2_sel;
            if (is_loaded) state_d = StWrite;
         end
         StStore: begin
            data_mux1_sel = Mux1Scalar;
            stride_sel    = sel.stride_sel;
            lumop_sel     = sel.lumop_sel;
            data_mux2_sel = sel.addr_mux2_sel;
            if (store_done) state_d = StIdle;
         end
         StWrite: begin
            vec_reg_wr_en  = 1'b1;
            data_mux1_sel  = sel.arith_mux1_sel;
            mask_operation = sel.mask_op;
            mask_wr_en     = sel.mask_op;
            if (data_written) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

`ifdef VEC_CTRL_TIMEOUT_EN
      // A completion strobe in the expiry cycle has already moved state_d and wins.
      if (timeout_hit && (state_d == state_q)) begin
         timeout_err    = 1'b1;
         csrwr_en       = 1'b0;
         vec_reg_wr_en  = 1'b0;
         mask_operation = 1'b0;
         mask_wr_en     = 1'b0;
         state_d        = StIdle;
      end
`endif
   end

endmodule

// File: tb/tb_vector_processor_controller.sv
// Scoreboard bench: stimulus queues the expected sequence of distinct output vectors,
// a monitor pops and compares one entry each time the sampled output vector changes.
module tb_vector_processor_controller;
   import vec_ctrl_pkg::*;

   typedef logic [17:0] ovec_t;
   typedef struct {
      ovec_t v;
      string name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic        csr_done = 1'b0;
   logic        is_loaded = 1'b0;
   logic        store_done = 1'b0;
   logic        data_written = 1'b0;
   logic        inst_ready, busy, vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel;
   logic        csrwr_en, vec_reg_wr_en, mask_operation, mask_wr_en;
   logic [1:0]  data_mux1_sel;
   logic        data_mux2_sel, stride_sel, ld_inst, illegal_inst;
   logic        tmo_bit;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   vector_processor_controller #(
      .XLEN_P         (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .inst_valid     (inst_valid),
      .instruction    (instruction),
      .inst_ready     (inst_ready),
      .busy           (busy),
      .csr_done       (csr_done),
      .is_loaded      (is_loaded),
      .store_done     (store_done),
      .data_written   (data_written),
      .vl_sel         (vl_sel),
      .vtype_sel      (vtype_sel),
      .lumop_sel      (lumop_sel),
      .rs1rd_de       (rs1rd_de),
      .rs1_sel        (rs1_sel),
      .csrwr_en       (csrwr_en),
      .vec_reg_wr_en  (vec_reg_wr_en),
      .mask_operation (mask_operation),
      .mask_wr_en     (mask_wr_en),
      .data_mux1_sel  (data_mux1_sel),
      .data_mux2_sel  (data_mux2_sel),
      .stride_sel     (stride_sel),
      .ld_inst        (ld_inst),
`ifdef VEC_CTRL_TIMEOUT_EN
      .timeout_err    (tmo_bit),
`endif
      .illegal_inst   (illegal_inst)
   );

`ifndef VEC_CTRL_TIMEOUT_EN
   assign tmo_bit = 1'b0;
`endif

   function automatic ovec_t mk(input logic rdy, input logic bsy, input logic vl,
                                input logic vt, input logic lum, input logic r1d,
                                input logic r1s, input logic cw, input logic vw,
                                input logic mop, input logic mw, input logic [1:0] m1,
                                input logic m2, input logic st, input logic ld,
                                input logic ill, input logic tmo);
      return {rdy, bsy, vl, vt, lum, r1d, r1s, cw, vw, mop, mw, m1, m2, st, ld, ill, tmo};
   endfunction

   ovec_t v_idle, v_dec, v_dec_ill, v_csr1, v_csr2, v_csri, v_load, v_wr_ld;
   ovec_t v_wr_imm, v_wr_x, v_wr_mask, v_store, v_store_tmo;

   initial begin
      v_idle      = mk(1,0, 0,0,0,0,0, 0,0,0,0, 2'b00,0,0,0, 0,0);
      v_dec       = mk(0,1, 0,0,0,0,0, 0,0,0,0, 2'b00,0,0,0, 0,0);
      v_dec_ill   = mk(0,1, 0,0,0,0,0, 0,0,0,0, 2'b00,0,0,0, 1,0);
      v_csr1      = mk(0,1, 0,1,0,1,0, 1,0,0,0, 2'b00,0,0,0, 0,0);
      v_csr2      = mk(0,1, 0,1,0,1,0, 0,0,0,0, 2'b00,0,0,0, 0,0);
      v_csri      = mk(0,1, 1,1,0,0,1, 1,0,0,0, 2'b00,0,0,0, 0,0);
      v_load      = mk(0,1, 0,0,1,0,0, 0,1,0,0, 2'b01,0,1,1, 0,0);
      v_wr_ld     = mk(0,1, 0,0,0,0,0, 0,1,0,0, 2'b00,0,0,0, 0,0);
      v_wr_imm    = mk(0,1, 0,0,0,0,0, 0,1,0,0, 2'b10,0,0,0, 0,0);
      v_wr_x      = mk(0,1, 0,0,0,0,0, 0,1,0,0, 2'b01,0,0,0, 0,0);
      v_wr_mask   = mk(0,1, 0,0,0,0,0, 0,1,1,1, 2'b00,0,0,0, 0,0);
      v_store     = mk(0,1, 0,0,0,0,0, 0,0,0,0, 2'b01,1,0,0, 0,0);
      v_store_tmo = mk(0,1, 0,0,0,0,0, 0,0,0,0, 2'b01,1,0,0, 0,1);
   end

   // Monitor: compare on every change of the observed output vector.
   initial begin : monitor
      ovec_t prev, cur;
      exp_t  e;
      prev = '1;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            cur = {inst_ready, busy, vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel,
                   csrwr_en, vec_reg_wr_en, mask_operation, mask_wr_en, data_mux1_sel,
                   data_mux2_sel, stride_sel, ld_inst, illegal_inst, tmo_bit};
            if (cur !== prev) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_output: got %b, required no further change", cur);
               end else begin
                  e = exp_q.pop_front();
                  if (cur !== e.v) begin
                     n_fail++;
                     $display("FAIL %s: got %b, required %b", e.name, cur, e.v);
                  end
               end
               prev = cur;
            end
         end
      end
   end

   task automatic expect_v(input ovec_t v, input string name);
      exp_t e;
      e.v    = v;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents the word for one cycle; returns one cycle into DECODE.
   task automatic issue(input logic [31:0] w);
      step();
      inst_valid  = 1'b1;
      instruction = w;
      step();
      inst_valid  = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      expect_v(v_idle, "reset_idle");
      step();
      mon_en = 1'b1;
      step();
      reset = 1'b0;

      // vsetvli x5, x10: two CSR cycles, csrwr_en only on the first
      expect_v(v_dec, "vsetvli_decode");
      expect_v(v_csr1, "vsetvli_csr_first");
      expect_v(v_csr2, "vsetvli_csr_hold");
      expect_v(v_idle, "vsetvli_idle");
      issue(32'h0D0572D7);
      step();
      step();
      csr_done = 1'b1;
      step();
      csr_done = 1'b0;

      // vsetivli with rs1 field 0, rd 3: done on the first CSR cycle
      expect_v(v_dec, "vsetivli_decode");
      expect_v(v_csri, "vsetivli_csr");
      expect_v(v_idle, "vsetivli_idle");
      issue(32'hCD0071D7);
      step();
      csr_done = 1'b1;
      step();
      csr_done = 1'b0;

      // vle32 unit-stride, with inst_valid pulses ignored while busy
      expect_v(v_dec, "vle32_decode");
      expect_v(v_load, "vle32_load");
      expect_v(v_wr_ld, "vle32_write");
      expect_v(v_idle, "vle32_idle");
      issue(32'h02056007);
      step();
      inst_valid  = 1'b1;
      instruction = 32'h00000033;
      step();
      inst_valid  = 1'b0;
      step();
      inst_valid  = 1'b1;
      step();
      inst_valid  = 1'b0;
      is_loaded   = 1'b1;
      step();
      is_loaded   = 1'b0;
      step();
      data_written = 1'b1;
      step();
      data_written = 1'b0;

      // vadd.vi / vadd.vx / vmseq.vv
      expect_v(v_dec, "vadd_vi_decode");
      expect_v(v_wr_imm, "vadd_vi_write");
      expect_v(v_idle, "vadd_vi_idle");
      issue(32'h0222B0D7);
      step();
      step();
      data_written = 1'b1;
      step();
      data_written = 1'b0;

      expect_v(v_dec, "vadd_vx_decode");
      expect_v(v_wr_x, "vadd_vx_write");
      expect_v(v_idle, "vadd_vx_idle");
      issue(32'h0222C0D7);
      step();
      data_written = 1'b1;
      step();
      data_written = 1'b0;

      expect_v(v_dec, "vmseq_decode");
      expect_v(v_wr_mask, "vmseq_write_mask");
      expect_v(v_idle, "vmseq_idle");
      issue(32'h62218057);
      step();
      step();
      data_written = 1'b1;
      step();
      data_written = 1'b0;

      // vsse32 strided store, completion on the first store cycle
      expect_v(v_dec, "vsse32_decode");
      expect_v(v_store, "vsse32_store");
      expect_v(v_idle, "vsse32_idle");
      issue(32'h0A62E0A7);
      step();
      store_done = 1'b1;
      step();
      store_done = 1'b0;

      // Illegal: scalar OP opcode, then OPFVV funct3 under the vector opcode
      expect_v(v_dec_ill, "illegal_op33");
      expect_v(v_idle, "illegal_op33_idle");
      issue(32'h00000033);
      step();
      expect_v(v_dec_ill, "illegal_opfvv");
      expect_v(v_idle, "illegal_opfvv_idle");
      issue(32'h00001057);
      step();

      // Reset held two cycles in the middle of a load, then recovery
      expect_v(v_dec, "rst_load_decode");
      expect_v(v_load, "rst_load_load");
      expect_v(v_idle, "rst_load_idle");
      issue(32'h02056007);
      step();
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      expect_v(v_dec, "post_rst_decode");
      expect_v(v_wr_imm, "post_rst_write");
      expect_v(v_idle, "post_rst_idle");
      issue(32'h0222B0D7);
      step();
      data_written = 1'b1;
      step();
      data_written = 1'b0;

`ifdef VEC_CTRL_TIMEOUT_EN
      // Store that never completes: error pulse in the 8th store cycle
      expect_v(v_dec, "tmo_decode");
      expect_v(v_store, "tmo_store");
      expect_v(v_store_tmo, "tmo_pulse");
      expect_v(v_idle, "tmo_idle");
      issue(32'h0A62E0A7);
      repeat (10) step();

      // Completion in the 8th store cycle wins over the watchdog
      expect_v(v_dec, "tmo_race_decode");
      expect_v(v_store, "tmo_race_store");
      expect_v(v_idle, "tmo_race_idle");
      issue(32'h0A62E0A7);
      repeat (8) step();
      store_done = 1'b1;
      step();
      store_done = 1'b0;
`endif

      repeat (4) step();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
